silife_matrix_8x8: RTL and testbench



---
 rtl/silife_matrix_8x8.sv | 75 +++++++
 tb/tb_silife_matrix_8x8.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/silife_matrix_8x8.sv
// silife_matrix_8x8: 8x8 Game of Life core, one generation per enabled clock.
// Ports: clk, reset (async, active-low), enable, row_select, set_cells, cells.
module silife_matrix_8x8 (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [2:0] row_select,
   input  logic [7:0] set_cells,
   output logic [7:0] cells
);

   // Cell (r,c) lives at bit r*8+c; 1 = alive.
   logic [63:0] cell_values;
   logic [63:0] next_values;
   logic [63:0] base_values;
   logic [63:0] set_mask;
   logic [5:0]  row_base;

   // 10x10 view with a ring of constant dead cells, so edge
   // cells see zeros outside the grid instead of wrapping.
   logic [9:0][9:0] pad;

   genvar i, j;
   generate
      for (i = 0; i < 10; i++) begin : g_pad_row
         for (j = 0; j < 10; j++) begin : g_pad_col
            if (i == 0 || i == 9 || j == 0 || j == 9) begin : g_edge
               assign pad[i][j] = 1'b0;
            end else begin : g_cell
               assign pad[i][j] = cell_values[(i-1)*8 + (j-1)];
            end
         end
      end
   endgenerate

   // Neighbour count is 4 bits so a count of 8 cannot overflow.
   generate
      for (i = 0; i < 8; i++) begin : g_row
         for (j = 0; j < 8; j++) begin : g_col
            logic [3:0] nbr;
            logic       alive;
            assign alive = pad[i+1][j+1];
            assign nbr = {3'b000, pad[i][j]}
                       + {3'b000, pad[i][j+1]}
                       + {3'b000, pad[i][j+2]}
                       + {3'b000, pad[i+1][j]}
                       + {3'b000, pad[i+1][j+2]}
                       + {3'b000, pad[i+2][j]}
                       + {3'b000, pad[i+2][j+1]}
                       + {3'b000, pad[i+2][j+2]};
            assign next_values[i*8 + j] =
               (nbr == 4'd3) | (alive & (nbr == 4'd2));
         end
      end
   endgenerate

   assign row_base = {row_select, 3'b000};

   // Set bits are OR'ed in after the rule, so a set always wins.
   always_comb begin
      base_values = enable ? next_values : cell_values;
      set_mask    = {56'd0, set_cells} << row_base;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cell_values <= 64'd0;
      end else begin
         cell_values <= base_values | set_mask;
      end
   end

   assign cells = cell_values[row_base +: 8];

endmodule

// File: tb/tb_silife_matrix_8x8.sv
// tb_silife_matrix_8x8: directed checks of the 8x8 Life core.
// Drives inputs 1ns after each rising edge and checks before the next.
module tb_silife_matrix_8x8;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [2:0] row_select;
   logic [7:0] set_cells;
   logic [7:0] cells;

   int passed;
   int total;

   silife_matrix_8x8 dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .row_select (row_select),
      .set_cells  (set_cells),
      .cells      (cells)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      #1;
      reset = 1'b1;
   endtask

   localparam logic [63:0] BLINK_H = 64'h0000_0070_0000_0000;
   localparam logic [63:0] BLINK_V = 64'h0000_2020_2000_0000;
   localparam logic [63:0] BLOCK   = 64'h0000_0000_1818_0000;

   logic [7:0] rows [8];

   initial begin
      passed     = 0;
      total      = 0;
      reset      = 1'b0;
      enable     = 1'b1;
      row_select = 3'd0;
      set_cells  = 8'hFF;
      rows = '{8'h81, 8'h42, 8'h24, 8'h18,
               8'h0F, 8'hF0, 8'hAA, 8'h55};

      // Reset held with sets active: board must stay clear.
      step();
      step();
      for (int r = 0; r < 8; r++) begin
         row_select = 3'(r);
         #1;
         chk("reset_cells", {56'd0, cells}, 64'd0);
      end
      chk("reset_state", dut.cell_values, 64'd0);

      // Release: empty board stays empty.
      reset     = 1'b1;
      set_cells = 8'h00;
      for (int k = 0; k < 5; k++) step();
      chk("empty_stays", dut.cell_values, 64'd0);

      // Blinker oscillation.
      row_select = 3'd4;
      set_cells  = 8'h70;
      step();
      set_cells = 8'h00;
      chk("blink_load", dut.cell_values, BLINK_H);
      chk("blink_row4", {56'd0, cells}, 64'h70);
      step();
      chk("blink_v1", dut.cell_values, BLINK_V);
      step();
      chk("blink_h2", dut.cell_values, BLINK_H);
      step();
      chk("blink_v2", dut.cell_values, BLINK_V);

      // Asynchronous reset between edges.
      reset = 1'b0;
      #1;
      chk("async_cells", {56'd0, cells}, 64'd0);
      chk("async_state", dut.cell_values, 64'd0);
      reset = 1'b1;
      step();

      // Block still life, loaded while held.
      enable     = 1'b0;
      row_select = 3'd2;
      set_cells  = 8'h18;
      step();
      row_select = 3'd3;
      step();
      set_cells = 8'h00;
      enable    = 1'b1;
      chk("block_load", dut.cell_values, BLOCK);
      for (int k = 0; k < 10; k++) begin
         step();
         chk("block_gen", dut.cell_values, BLOCK);
      end

      // Lone corner cell dies: no wrap-around.
      pulse_reset();
      enable     = 1'b0;
      row_select = 3'd0;
      set_cells  = 8'h01;
      step();
      chk("corner_load", dut.cell_values, 64'h1);
      set_cells = 8'h00;
      enable    = 1'b1;
      step();
      chk("corner_dies", dut.cell_values, 64'd0);

      // Enable low holds the generation.
      enable     = 1'b0;
      row_select = 3'd4;
      set_cells  = 8'h70;
      step();
      set_cells = 8'h00;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("hold_gen", dut.cell_values, BLINK_H);
      end
      row_select = 3'd0;
      set_cells  = 8'h01;
      step();
      set_cells = 8'h00;
      chk("hold_set", dut.cell_values, BLINK_H | 64'h1);
      step();
      chk("hold_after", dut.cell_values, BLINK_H | 64'h1);

      // Set overrides the rule killing a lone cell.
      pulse_reset();
      enable     = 1'b1;
      row_select = 3'd7;
      set_cells  = 8'h80;
      step();
      chk("set_win1", dut.cell_values, 64'h8000_0000_0000_0000);
      step();
      chk("set_win2", dut.cell_values, 64'h8000_0000_0000_0000);
      set_cells = 8'h00;
      step();
      chk("set_release", dut.cell_values, 64'd0);

      // Read mux sweep over a held pattern.
      enable = 1'b0;
      for (int r = 0; r < 8; r++) begin
         row_select = 3'(r);
         set_cells  = rows[r];
         step();
      end
      set_cells = 8'h00;
      for (int r = 0; r < 8; r++) begin
         row_select = 3'(r);
         #1;
         chk("mux_row", {56'd0, cells}, {56'd0, rows[r]});
         chk("mux_vs_state", {56'd0, cells},
             {56'd0, dut.cell_values[r*8 +: 8]});
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
